// File: rtl/fractal_sync_rx_node.sv
// Fractal sync responder: joins two child barrier requests, completes them locally or via the parent.
// Local wake 2 cycles after the last arrival; forwarded barriers hold in UP_WAIT until the parent wakes.
module fractal_sync_rx_node #(
   parameter int unsigned LVL_W    = 4,
   parameter int unsigned NODE_LVL = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clear_i,
   input  logic [1:0]           c_sync_i,
   input  logic [2*LVL_W-1:0]   c_level_i,
   input  logic [1:0]           c_ack_i,
   output logic [1:0]           c_wake_o,
   output logic [1:0]           c_error_o,
   output logic                 p_sync_o,
   output logic [LVL_W-1:0]     p_level_o,
   output logic                 p_ack_o,
   input  logic                 p_wake_i,
   input  logic                 p_error_i
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_UP_SYNC,
      S_UP_WAIT,
      S_UP_ACK,
      S_WAKE
   } state_e;

   localparam logic [LVL_W-1:0] NODE_LVL_L = LVL_W'(NODE_LVL);

   state_e                  state_q, state_d;
   logic [1:0]              arr_q, arr_d;
   logic [1:0][LVL_W-1:0]   lvl_q, lvl_d;
   logic [1:0]              wpend_q, wpend_d;
   logic                    err_q, err_d;

   logic                    decide;
   logic                    lvl_bad;
   logic                    lvl_local;
   logic                    enter_wake;

   assign decide    = (state_q == S_IDLE) && (arr_q == 2'b11) && (wpend_q == 2'b00);
   assign lvl_bad   = (lvl_q[0] != lvl_q[1]) || (lvl_q[0] < NODE_LVL_L);
   assign lvl_local = (lvl_q[0] == NODE_LVL_L);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (decide) begin
               state_d = (lvl_bad || lvl_local) ? S_WAKE : S_UP_SYNC;
            end
         end
         S_UP_SYNC: state_d = S_UP_WAIT;
         S_UP_WAIT: begin
            if (p_wake_i) begin
               state_d = S_UP_ACK;
            end
         end
         S_UP_ACK:  state_d = S_WAKE;
         S_WAKE: begin
            if (wpend_q == 2'b00) begin
               state_d = S_IDLE;
            end
         end
         default:   state_d = S_IDLE;
      endcase
      if (clear_i) begin
         state_d = S_IDLE;
      end
   end

   assign enter_wake = (state_d == S_WAKE) && (state_q != S_WAKE);

   // ---------------- FSM: outputs (registered state only) ----------------
   always_comb begin
      c_wake_o  = 2'b00;
      c_error_o = 2'b00;
      p_sync_o  = 1'b0;
      p_level_o = '0;
      p_ack_o   = 1'b0;
      unique case (state_q)
         S_UP_SYNC: begin
            p_sync_o  = 1'b1;
            p_level_o = lvl_q[0];
         end
         S_UP_ACK:  p_ack_o = 1'b1;
         S_WAKE: begin
            c_wake_o  = wpend_q;
            c_error_o = wpend_q & {2{err_q}};
         end
         default: ;
      endcase
   end

   // ---------------- Arrival / wake / error bookkeeping ----------------
   always_comb begin
      arr_d   = arr_q;
      lvl_d   = lvl_q;
      wpend_d = wpend_q;
      err_d   = err_q;

      // Arrivals latch in every state so a child may post its next barrier early.
      for (int c = 0; c < 2; c++) begin
         if (c_sync_i[c] && !arr_q[c]) begin
            arr_d[c] = 1'b1;
            lvl_d[c] = c_level_i[c*LVL_W +: LVL_W];
         end
      end

      if (state_q == S_WAKE) begin
         wpend_d = wpend_q & ~c_ack_i;
      end

      if (decide) begin
         err_d = lvl_bad;
      end

      if ((state_q == S_UP_WAIT) && p_wake_i) begin
         err_d = p_error_i;
      end

      // The consumed barrier is cleared on entry, overriding a same-cycle arrival.
      if (enter_wake) begin
         arr_d   = 2'b00;
         wpend_d = 2'b11;
      end

      if (clear_i) begin
         arr_d   = 2'b00;
         lvl_d   = '0;
         wpend_d = 2'b00;
         err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         arr_q   <= 2'b00;
         lvl_q   <= '0;
         wpend_q <= 2'b00;
         err_q   <= 1'b0;
      end else begin
         arr_q   <= arr_d;
         lvl_q   <= lvl_d;
         wpend_q <= wpend_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: doc/fractal_sync_rx_node.md
# fractal_sync_rx_node

Responder end of the fractal synchronization interface. Collects barrier requests from two child `fractal_if` master ports, such as tile instruction decoders or lower nodes. A barrier whose level equals this node's level completes locally. A barrier at a higher level is forwarded to the parent port and completes when the parent wakes this node. It sits in the fractal sync tree between tiles (or lower nodes) and the next tree level.

## Interface
Parameters:
- `LVL_W`, 4: width of all level fields.
- `NODE_LVL`, 1: level at which this node terminates a barrier. Must be ≥1.

Ports (all synchronous to `clk_i`):
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  asynchronous reset, active-high.
- `clear_i`  in  1  synchronous clear; same effect as reset.
- `c_sync_i`  in  2  per-child one-cycle sync request pulse.
- `c_level_i`  in  2×LVL_W  per-child level; valid with `c_sync_i`.
- `c_ack_i`  in  2  per-child wake acknowledge pulse.
- `c_wake_o`  out  2  per-child wake; held until that child acks.
- `c_error_o`  out  2  per-child error; qualified by `c_wake_o`.
- `p_sync_o`  out  1  parent sync pulse.
- `p_level_o`  out  LVL_W  parent level; valid with `p_sync_o`, 0 otherwise.
- `p_ack_o`  out  1  parent acknowledge pulse.
- `p_wake_i`  in  1  parent wake.
- `p_error_i`  in  1  parent error; sampled with `p_wake_i`.

## Operation
Per-child registers:
- `arr[c]` (arrived), `lvl[c]`, `wpend[c]` (awaiting ack), plus one `err_q`.
- On `c_sync_i[c]` with `arr[c]`=0: set `arr[c]`, latch `lvl[c]`. A sync while `arr[c]`=1 is ignored and does not overwrite the level.
- Arrival latching is active in every state, so a child can post its next barrier while the other child is still acking.

FSM states: IDLE, UP_SYNC, UP_WAIT, UP_ACK, WAKE.
- IDLE, with `arr`=2'b11 and `wpend`=0, decides the barrier:
  - Error if `lvl[0]≠lvl[1]` or `lvl[0]<NODE_LVL`: `err_q`←1, go to WAKE.
  - Local if `lvl[0]==NODE_LVL`: `err_q`←0, go to WAKE.
  - Otherwise (`lvl[0]>NODE_LVL`): `err_q`←0, go to UP_SYNC.
- IDLE otherwise: hold.
- UP_SYNC: `p_sync_o`=1 and `p_level_o`=`lvl[0]` (level passed unchanged) for one cycle, then go to UP_WAIT.
- UP_WAIT: hold until `p_wake_i`=1, then `err_q`←`p_error_i` and go to UP_ACK.
- UP_ACK: `p_ack_o`=1 for one cycle, then go to WAKE.
- On entry to WAKE: `arr`←0 and `wpend`←2'b11. This clear has priority over a same-cycle arrival only for the entering cycle.
- WAKE:
  - `c_wake_o[c]`=`wpend[c]` and `c_error_o[c]`=`wpend[c]&err_q`.
  - `c_ack_i[c]` while `wpend[c]`=1 clears `wpend[c]`. An ack while `wpend[c]`=0 is ignored.
  - When `wpend`=0, return to IDLE.
- Reset/clear (mid-operation too): all state goes to IDLE, all registers to 0, all outputs to 0. An outstanding parent transaction is abandoned.

## Timing
- Reset values: `c_wake_o`=0, `c_error_o`=0, `p_sync_o`=0, `p_level_o`=0, `p_ack_o`=0.
- All outputs are decoded from registered state only; no input-to-output combinational path.
- Local barrier: later sync in cycle t → `arr` full at t+1 (IDLE decides) → `c_wake_o`=2'b11 from t+2.
- Forward barrier:
  - Later sync in cycle t → `p_sync_o` in cycle t+2.
  - `p_wake_i` seen in cycle u → `p_ack_o` in u+1 → `c_wake_o` from u+2.
- Simultaneous syncs from both children in one cycle are equivalent to arrivals in order.
- WAKE→IDLE takes one cycle after the last ack is sampled. Minimum barrier-to-barrier turnaround is therefore 2 cycles after the last ack.

## Test plan
- Local barrier, NODE_LVL=1: child0 sync level 1 at cycle 5, child1 at 9 → `c_wake_o`=11 at 11, `c_error_o`=00. Acks at 13 (child0) and 15 (child1) → wake bits drop at 14 and 16 respectively; IDLE at 17.
- Forward: both children sync level 3 at cycle 4 → `p_sync_o` with `p_level_o`=3 at 6. `p_wake_i` at 10 → `p_ack_o` at 11, `c_wake_o`=11 at 12, no child wake before that.
- Mismatch: child levels 1 and 2 → `c_wake_o`=11 and `c_error_o`=11; no `p_sync_o`.
- Parent error: forward barrier with `p_error_i`=1 during wake → `c_error_o`=11 during WAKE.
- Overlap: child0 acks, then syncs level 1 while child1's wake is pending. Child1 acks, then syncs level 1 → second barrier wakes both. The early sync from child0 is not lost.
- `rst_i` pulsed in UP_WAIT → all outputs 0; a subsequent local barrier completes normally.
